// File: rtl/mem_port_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_pkg
// Shared types and helpers for the memory-port requester.
//   mem_req_t  : request as presented on the valid/ready side {we, addr, wdata}
//   mem_rsp_t  : read response held in the response FIFO {addr, data}
//   pipe_len() : number of tracking stages needed for a given memory latency
// The struct field widths follow MP_WIDTH / MP_ADDR_WIDTH. The requester
// defaults its WIDTH / ADDR_WIDTH parameters to these values.
// ---------------------------------------------------------------------------
package mem_port_pkg;

  localparam int MP_WIDTH      = 8;
  localparam int MP_ADDR_WIDTH = 3;

  typedef struct packed {
    logic                     we;
    logic [MP_ADDR_WIDTH-1:0] addr;
    logic [MP_WIDTH-1:0]      wdata;
  } mem_req_t;

  typedef struct packed {
    logic [MP_ADDR_WIDTH-1:0] addr;
    logic [MP_WIDTH-1:0]      data;
  } mem_rsp_t;

  // One extra stage covers the edge spent in the registered memory outputs.
  function automatic int pipe_len(input int latency);
    return latency + 1;
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// ---------------------------------------------------------------------------
// mem_rsp_fifo
// Synchronous first-word-fall-through FIFO of mem_rsp_t.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write side (ignored when full unless a pop frees a slot)
//   pop_i/data_o  : read side, data_o shows the head entry while not empty
//   full_o, empty_o, count_o : occupancy status
// Pointers carry one wrap bit so full/empty need no separate counter.
// ---------------------------------------------------------------------------
module mem_rsp_fifo
  import mem_port_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  mem_rsp_t               data_i,
  input  logic                   pop_i,
  output mem_rsp_t               data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  mem_rsp_t      store_q [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // Head is forced to zero when empty so the outputs read 0 in reset.
  assign data_o = empty_o ? '0 : store_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) store_q[wr_ptr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mem_port_requester.sv
// ---------------------------------------------------------------------------
// mem_port_requester
// Initiator for one port of a fixed-latency memory. Requests arrive on a
// valid/ready interface and are registered onto the memory port; read data
// is captured READ_LATENCY edges after the memory samples the read and is
// returned in order through a FWFT response FIFO tagged with its address.
//   i_clk, i_rst_n                   : clock, asynchronous active-low reset
//   i_req_* / o_req_ready            : request channel (we, addr, wdata)
//   o_rsp_* / i_rsp_ready            : read response channel (data, addr)
//   o_mem_en/we/addr/din, i_mem_dout : memory port
//   o_busy                           : any write/read in flight or FIFO non-empty
// Reads are admitted only with a free FIFO credit (in-flight + stored < depth)
// and never while a write to the same address is still committing.
// ---------------------------------------------------------------------------
module mem_port_requester
  import mem_port_pkg::*;
#(
  parameter int WIDTH         = MP_WIDTH,
  parameter int ADDR_WIDTH    = MP_ADDR_WIDTH,
  parameter int WRITE_LATENCY = 4,
  parameter int READ_LATENCY  = 5,
  parameter int RSP_DEPTH     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [WIDTH-1:0]      i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH-1:0]      o_rsp_data,
  output logic [ADDR_WIDTH-1:0] o_rsp_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0]      o_mem_din,
  input  logic [WIDTH-1:0]      i_mem_dout,
  output logic                  o_busy
);

  localparam int RD_STAGES = pipe_len(READ_LATENCY);
  localparam int WR_STAGES = pipe_len(WRITE_LATENCY);
  localparam int CNT_W     = $clog2(RSP_DEPTH) + 1;
  localparam int SUM_W     = $clog2(RSP_DEPTH + RD_STAGES + 1) + 1;

  mem_req_t               req;
  mem_req_t               mem_q, mem_d;
  logic                   mem_en_q;
  logic [RD_STAGES-1:0]   rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q [RD_STAGES];
  logic [WR_STAGES-1:0]   wr_vld_q, wr_vld_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q [WR_STAGES];

  logic                   accept, rsp_pop, raw_hit, rd_ok;
  logic [SUM_W-1:0]       credits_used;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full, fifo_empty;
  mem_rsp_t               fifo_din, fifo_dout;

  assign req = '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata};

  assign rsp_pop = ~fifo_empty & i_rsp_ready;

  // Credits include the pop happening on this edge so a full set of credits
  // can be refilled in the same cycle a response leaves.
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < WR_STAGES; i++) begin
      if (wr_vld_q[i] && (wr_addr_q[i] == i_req_addr)) raw_hit = 1'b1;
    end
    credits_used = SUM_W'(fifo_count);
    for (int i = 0; i < RD_STAGES; i++) begin
      credits_used = credits_used + SUM_W'(rd_vld_q[i]);
    end
    if (rsp_pop) credits_used = credits_used - SUM_W'(1);
  end

  assign rd_ok = (credits_used < SUM_W'(RSP_DEPTH)) && !raw_hit &&
                 !(fifo_full && !rsp_pop);

  assign o_req_ready = i_rst_n & (i_req_we | rd_ok);
  assign accept      = i_req_valid & o_req_ready;

  assign rd_vld_d = {rd_vld_q[RD_STAGES-2:0], accept & ~i_req_we};
  assign wr_vld_d = {wr_vld_q[WR_STAGES-2:0], accept &  i_req_we};
  assign mem_d    = accept ? req : mem_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_en_q <= 1'b0;
      mem_q    <= '0;
      rd_vld_q <= '0;
      wr_vld_q <= '0;
      for (int i = 0; i < RD_STAGES; i++) rd_addr_q[i] <= '0;
      for (int i = 0; i < WR_STAGES; i++) wr_addr_q[i] <= '0;
    end else begin
      mem_en_q     <= accept;
      mem_q        <= mem_d;
      rd_vld_q     <= rd_vld_d;
      wr_vld_q     <= wr_vld_d;
      rd_addr_q[0] <= i_req_addr;
      wr_addr_q[0] <= i_req_addr;
      for (int i = 1; i < RD_STAGES; i++) rd_addr_q[i] <= rd_addr_q[i-1];
      for (int i = 1; i < WR_STAGES; i++) wr_addr_q[i] <= wr_addr_q[i-1];
    end
  end

  // The last read stage lines up with the edge where dout holds its data.
  assign fifo_din = '{addr: rd_addr_q[RD_STAGES-1], data: i_mem_dout};

  mem_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (rd_vld_q[RD_STAGES-1]),
    .data_i  (fifo_din),
    .pop_i   (i_rsp_ready),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_q.we;
  assign o_mem_addr  = mem_q.addr;
  assign o_mem_din   = mem_q.wdata;
  assign o_rsp_valid = ~fifo_empty;
  assign o_rsp_data  = fifo_dout.data;
  assign o_rsp_addr  = fifo_dout.addr;
  assign o_busy      = (|rd_vld_q) | (|wr_vld_q) | ~fifo_empty;

endmodule

// File: tb/tb_mem_port_requester.sv
module tb_mem_port_requester;

  localparam int WL = 4;
  localparam int RL = 5;

  logic       clk = 1'b0;
  logic       rst_n, mem_rst_n;
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_addr;
  logic       mem_en, mem_we;
  logic [2:0] mem_addr;
  logic [7:0] mem_din, mem_dout;
  logic       busy;

  always #5 clk = ~clk;

  mem_port_requester dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_addr  (rsp_addr),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_din   (mem_din),
    .i_mem_dout  (mem_dout),
    .o_busy      (busy)
  );

  // Memory model: write committed WL edges after sampling, read data on dout
  // in the cycle that ends RL edges after sampling.
  logic [7:0] marr  [8];
  logic [7:0] rpipe [RL];
  logic       wv    [WL];
  logic [2:0] wa    [WL];
  logic [7:0] wd    [WL];

  always @(posedge clk) begin
    if (!mem_rst_n) begin
      for (int i = 0; i < 8; i++) marr[i] <= 8'd0;
      for (int i = 0; i < WL; i++) wv[i] <= 1'b0;
    end else begin
      if (wv[WL-1]) marr[wa[WL-1]] <= wd[WL-1];
      wv[0] <= mem_en && mem_we;
      for (int i = 1; i < WL; i++) wv[i] <= wv[i-1];
    end
    wa[0] <= mem_addr;
    wd[0] <= mem_din;
    for (int i = 1; i < WL; i++) begin
      wa[i] <= wa[i-1];
      wd[i] <= wd[i-1];
    end
    rpipe[0] <= marr[mem_addr];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_dout = rpipe[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [10:0] sb_q[$];
  logic [7:0]  shadow [8];
  int rise_cyc = -1;
  bit rnd_on = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every popped response against the queue head.
  initial begin
    logic prev_vld;
    logic [10:0] exp;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid && !prev_vld && rise_cyc < 0) rise_cyc = cyc;
      prev_vld = rsp_valid;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected got addr %0d data %0d expected none", rsp_addr, rsp_data);
        end else begin
          exp = sb_q.pop_front();
          check("rsp_addr", int'(rsp_addr), int'(exp[10:8]));
          check("rsp_data", int'(rsp_data), int'(exp[7:0]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Issue one request; exp < 0 means take the expected read data from shadow.
  task automatic issue(input logic we, input logic [2:0] a, input logic [7:0] d,
                       input int exp, output int acc_cyc);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    acc_cyc   = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req_ready) begin
        acc_cyc = cyc + 1;
        if (we) shadow[a] = d;
        else sb_q.push_back({a, (exp < 0) ? shadow[a] : 8'(exp)});
        break;
      end
    end
    if (acc_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got no accept expected accept addr %0d", a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, int'(busy), 0);
    check({name, "_sb"}, sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t, k0, kw, kr, acc, cnt;
    rst_n = 1'b0; mem_rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b1; req_addr = 3'd0; req_wdata = 8'd0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) shadow[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_mem_en", int'(mem_en), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1; mem_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write 12@0, 13@1, read 0,1,0 back-to-back.
    issue(1'b1, 3'd0, 8'd12, 0, t);
    issue(1'b1, 3'd1, 8'd13, 0, t);
    rise_cyc = -1;
    issue(1'b0, 3'd0, 8'd0, 12, k0);
    issue(1'b0, 3'd1, 8'd0, 13, t);
    issue(1'b0, 3'd0, 8'd0, 12, t);
    repeat (12) @(posedge clk);
    #1;
    check("rd_latency", rise_cyc - k0, 6);
    wait_idle("idle_t1");

    // Read-after-write hazard on addr 2.
    issue(1'b1, 3'd2, 8'd9, 0, kw);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
    @(negedge clk);
    check("raw_block", int'(req_ready), 0);
    @(posedge clk);
    #1;
    issue(1'b0, 3'd2, 8'd0, 9, kr);
    check("raw_wait", kr - kw, 6);
    wait_idle("idle_t2");

    // Credit limit with responses held.
    rsp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (req_ready && acc < 12) begin
        sb_q.push_back({req_addr, shadow[req_addr]});
        acc++;
      end
      @(posedge clk);
      #1;
      req_addr = 3'(acc);
      if (acc >= 12) req_valid = 1'b0;
    end
    check("credit_accepts", acc, 8);
    @(negedge clk);
    check("credit_block", int'(req_ready), 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b1; req_addr = 3'd7; req_wdata = 8'd77;
    @(negedge clk);
    check("wr_while_full", int'(req_ready), 1);
    @(posedge clk);
    #1;
    issue(1'b1, 3'd7, 8'd77, 0, t);
    rsp_ready = 1'b1;
    wait_idle("idle_t3");

    // Same-edge pop and read with all credits used.
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(1'b0, 3'(i), 8'd0, -1, t);
    repeat (10) @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
    @(negedge clk);
    check("full_credit_block", int'(req_ready), 0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pop_frees_credit", int'(req_ready), 1);
    if (req_ready) sb_q.push_back({3'd3, shadow[3]});
    @(posedge clk);
    #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    check("credits_still_8", int'(req_ready), 0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle("idle_t4");

    // Reset with three reads in flight.
    issue(1'b0, 3'd0, 8'd0, -1, t);
    issue(1'b0, 3'd1, 8'd0, -1, t);
    issue(1'b0, 3'd2, 8'd0, -1, t);
    check("pre_rst_mem_en", int'(mem_en), 1);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("rst_mem_en_now", int'(mem_en), 0);
    check("rst_rsp_valid_now", int'(rsp_valid), 0);
    check("rst_busy_now", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("no_rsp_after_rst", cnt, 0);
    @(posedge clk);
    #1;

    // Random mixed traffic against the shadow model.
    rnd_on = 1'b1;
    for (int n = 0; n < 60; n++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)), -1, t);
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    wait_idle("idle_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
